// File: rtl/execute_pipe_if.sv
// Handshake and data bundle for execute_pipe.
// master: the side that issues operations and consumes results (upstream/downstream agent).
// slave:  the execute stage itself.
interface execute_pipe_if #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] pc_next;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic              reg_dst;
    logic              alu_src;
    logic [1:0]        alu_op;
    logic [3:0]        func;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] branch_target;
    logic              zero;
    logic [REG_W-1:0]  dest_reg;

    modport master (
        output in_valid, pc_next, rs_data, rt_data, imm, rs, rt, rd,
               reg_dst, alu_src, alu_op, func, out_ready,
        input  in_ready, out_valid, alu_result, branch_target, zero, dest_reg
    );

    modport slave (
        input  in_valid, pc_next, rs_data, rt_data, imm, rs, rt, rd,
               reg_dst, alu_src, alu_op, func, out_ready,
        output in_ready, out_valid, alu_result, branch_target, zero, dest_reg
    );
endinterface

// File: rtl/execute_pipe.sv
// Execute stage: single-cycle ALU ops plus a DATA_W-cycle shift-add multiplier.
// Optional result forwarding from the held output is enabled by defining
// EXECUTE_PIPE_FWD_EN; without it rs_data/rt_data are used as presented.
//
// state | meaning
// IDLE  | ready for a new op (when the output slot is free or draining)
// MUL   | iterating the shift-add multiplier, one step per cycle
module execute_pipe #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
) (
    input  logic          clk,
    input  logic          rst,
    execute_pipe_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic {IDLE, MUL} state_t;
    typedef enum logic [2:0] {F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_SLT, F_MUL} fn_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] mcand_q, mplier_q, acc_q;
    logic [DATA_W-1:0] alu_result_q, branch_target_q;
    logic              zero_q, out_valid_q;
    logic [REG_W-1:0]  dest_reg_q;

    fn_t               fn;
    logic              accept, mul_done;
    logic [DATA_W-1:0] op_a, op_rt, op_b, alu_val, acc_step, branch_calc;

    assign bus.in_ready      = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept            = bus.in_valid && bus.in_ready;
    assign mul_done          = (state_q == MUL) && (cnt_q == CNT_W'(1));
    assign acc_step          = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign branch_calc       = bus.pc_next + {bus.imm[DATA_W-2:0], 1'b0};

    assign bus.out_valid     = out_valid_q;
    assign bus.alu_result    = alu_result_q;
    assign bus.branch_target = branch_target_q;
    assign bus.zero          = zero_q;
    assign bus.dest_reg      = dest_reg_q;

    // Decode alu_op/func into a single operation code.
    always_comb begin
        fn = F_ADD;
        case (bus.alu_op)
            2'b00: fn = F_ADD;
            2'b01: fn = F_SUB;
            2'b11: fn = F_OR;
            default: begin
                case (bus.func)
                    4'b0000: fn = F_ADD;
                    4'b0001: fn = F_SUB;
                    4'b0010: fn = F_AND;
                    4'b0011: fn = F_OR;
                    4'b0100: fn = F_XOR;
                    4'b0101: fn = F_SLT;
                    4'b0110: fn = F_MUL;
                    default: fn = F_ADD;
                endcase
            end
        endcase
    end

`ifdef EXECUTE_PIPE_FWD_EN
    // Operand selection; a held, still-valid result overrides a stale register read.
    always_comb begin
        op_a  = bus.rs_data;
        op_rt = bus.rt_data;
        if (out_valid_q && (dest_reg_q == bus.rs) && (bus.rs != '0)) op_a  = alu_result_q;
        if (out_valid_q && (dest_reg_q == bus.rt) && (bus.rt != '0)) op_rt = alu_result_q;
        op_b = bus.alu_src ? bus.imm : op_rt;
    end
`else
    logic unused_rs;
    assign unused_rs = ^bus.rs;

    // Operand selection straight from the register read ports.
    always_comb begin
        op_a  = bus.rs_data;
        op_rt = bus.rt_data;
        op_b  = bus.alu_src ? bus.imm : op_rt;
    end
`endif

    // Single-cycle ALU; MUL is handled by the iterative path, so it falls to ADD here.
    always_comb begin
        alu_val = op_a + op_b;
        case (fn)
            F_SUB:   alu_val = op_a - op_b;
            F_AND:   alu_val = op_a & op_b;
            F_OR:    alu_val = op_a | op_b;
            F_XOR:   alu_val = op_a ^ op_b;
            F_SLT: begin
                alu_val    = '0;
                alu_val[0] = ($signed(op_a) < $signed(op_b));
            end
            default: alu_val = op_a + op_b;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: a MUL accept starts iteration, the last step returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && (fn == F_MUL)) state_d = MUL;
            MUL:     if (mul_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output registers, handshake flag and multiplier datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q           <= '0;
            mcand_q         <= '0;
            mplier_q        <= '0;
            acc_q           <= '0;
            alu_result_q    <= '0;
            branch_target_q <= '0;
            zero_q          <= 1'b0;
            out_valid_q     <= 1'b0;
            dest_reg_q      <= '0;
        end else begin
            if (mul_done) begin
                alu_result_q <= acc_step;
                zero_q       <= (acc_step == '0);
                out_valid_q  <= 1'b1;
            end else if (accept) begin
                // dest/branch are captured now; out_valid stays low through MUL so updating them early is invisible.
                dest_reg_q      <= bus.reg_dst ? bus.rd : bus.rt;
                branch_target_q <= branch_calc;
                if (fn == F_MUL) begin
                    out_valid_q <= 1'b0;
                    cnt_q       <= CNT_W'(DATA_W);
                    mcand_q     <= op_a;
                    mplier_q    <= op_b;
                    acc_q       <= '0;
                end else begin
                    alu_result_q <= alu_val;
                    zero_q       <= (alu_val == '0);
                    out_valid_q  <= 1'b1;
                end
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (state_q == MUL) begin
                acc_q    <= acc_step;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_execute_pipe.sv
// Directed bench for execute_pipe: driver pushes expected results into a
// scoreboard at acceptance, a monitor pops and compares on each output handshake.
module tb_execute_pipe;
    localparam int DATA_W = 16;
    localparam int REG_W  = 3;

    typedef struct packed {
        logic [15:0] res;
        logic [15:0] bt;
        logic        zero;
        logic [2:0]  dest;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    execute_pipe_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();
    execute_pipe #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   bad;

    function automatic exp_t mk(logic [15:0] res, logic [15:0] bt, logic zero, logic [2:0] dest);
        exp_t e;
        e.res = res; e.bt = bt; e.zero = zero; e.dest = dest;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Drive one op, wait (bounded) for acceptance, record the expected result.
    task automatic issue(input logic [1:0] aop, input logic [3:0] fn, input logic asrc, input logic rdst,
                         input logic [2:0] rs_i, input logic [2:0] rt_i, input logic [2:0] rd_i,
                         input logic [15:0] a, input logic [15:0] b, input logic [15:0] im,
                         input logic [15:0] pc, input logic push_exp, input exp_t e);
        int waited;
        bus.alu_op = aop; bus.func = fn; bus.alu_src = asrc; bus.reg_dst = rdst;
        bus.rs = rs_i; bus.rt = rt_i; bus.rd = rd_i;
        bus.rs_data = a; bus.rt_data = b; bus.imm = im; bus.pc_next = pc;
        bus.in_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready still 0 after %0d cycles, expected 1", waited);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (push_exp) sb_q.push_back(e);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int waited;
        waited = 0;
        while (sb_q.size() != 0 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        check(name, sb_q.size(), 0);
    endtask

    // Monitor: compare every output handshake against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got res=0x%0h dest=%0d, expected no output",
                         bus.alu_result, bus.dest_reg);
            end else begin
                mon_e = sb_q.pop_front();
                if ({bus.alu_result, bus.branch_target, bus.zero, bus.dest_reg} !== mon_e) begin
                    n_fail++;
                    $display("FAIL output_compare: got res=0x%0h bt=0x%0h zero=%0b dest=%0d, expected res=0x%0h bt=0x%0h zero=%0b dest=%0d",
                             bus.alu_result, bus.branch_target, bus.zero, bus.dest_reg,
                             mon_e.res, mon_e.bt, mon_e.zero, mon_e.dest);
                end
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.alu_op = '0; bus.func = '0; bus.alu_src = 1'b0; bus.reg_dst = 1'b0;
        bus.rs = '0; bus.rt = '0; bus.rd = '0;
        bus.rs_data = '0; bus.rt_data = '0; bus.imm = '0; bus.pc_next = '0;

        // Reset state
        #2;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_alu_result", bus.alu_result, 0);
        check("rst_branch_target", bus.branch_target, 0);
        check("rst_zero", bus.zero, 0);
        check("rst_dest_reg", bus.dest_reg, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1);

        // 0x7FFF + 1 via func ADD, latency 1
        align();
        issue(2'b10, 4'b0000, 0, 1, 0, 0, 3, 16'h7FFF, 16'h0001, 16'h0004, 16'h0100, 1,
              mk(16'h8000, 16'h0108, 0, 3));
        @(negedge clk);
        check("add_latency_valid", bus.out_valid, 1);

        // SUB to zero, negative immediate branch offset, dest from rt
        align();
        issue(2'b01, 4'b0000, 0, 0, 0, 5, 7, 16'h1234, 16'h1234, 16'hFFFE, 16'h0010, 1,
              mk(16'h0000, 16'h000C, 1, 5));
        @(negedge clk);
        check("sub_latency_valid", bus.out_valid, 1);

        // Back-to-back single-cycle ops
        align();
        issue(2'b10, 4'b0010, 1, 1, 0, 0, 1, 16'hF0F0, 16'h9999, 16'h0FF0, 16'h0000, 1,
              mk(16'h00F0, 16'h1FE0, 0, 1));
        issue(2'b10, 4'b0100, 0, 1, 0, 0, 2, 16'hAAAA, 16'hFFFF, 16'h0000, 16'h0000, 1,
              mk(16'h5555, 16'h0000, 0, 2));
        issue(2'b10, 4'b0101, 0, 1, 0, 0, 3, 16'hFFFF, 16'h0001, 16'h0000, 16'h0020, 1,
              mk(16'h0001, 16'h0020, 0, 3));
        issue(2'b10, 4'b0101, 0, 1, 0, 0, 4, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 1,
              mk(16'h0000, 16'h0000, 1, 4));
        issue(2'b11, 4'b0101, 0, 1, 0, 0, 5, 16'h1200, 16'h0034, 16'h0002, 16'h0004, 1,
              mk(16'h1234, 16'h0008, 0, 5));
        issue(2'b00, 4'b0001, 1, 1, 0, 0, 6, 16'hFFFF, 16'h1111, 16'h0002, 16'hFFFF, 1,
              mk(16'h0001, 16'h0003, 0, 6));
        issue(2'b10, 4'b1111, 0, 1, 0, 0, 7, 16'h0003, 16'h0004, 16'h0000, 16'h0000, 1,
              mk(16'h0007, 16'h0000, 0, 7));
        drain("alu_drain");

        // MUL 0x12 * 0x34: busy 16 cycles, result on cycle 17; inputs scrambled meanwhile
        align();
        issue(2'b10, 4'b0110, 0, 1, 0, 0, 2, 16'h0012, 16'h0034, 16'h0003, 16'h0040, 1,
              mk(16'h03A8, 16'h0046, 0, 2));
        bus.rs_data = 16'hFFFF; bus.rt_data = 16'hFFFF; bus.imm = 16'h7777;
        bus.pc_next = 16'h5555; bus.rd = 3'd0; bus.reg_dst = 1'b0;
        bad = 0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k <= 16) begin
                if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) bad++;
            end else begin
                check("mul_done_valid", bus.out_valid, 1);
            end
        end
        check("mul_busy_cycles", bad, 0);

        // MUL truncation and MUL producing zero
        align();
        issue(2'b10, 4'b0110, 1, 0, 0, 3, 0, 16'h1234, 16'h0000, 16'h0100, 16'h0000, 1,
              mk(16'h3400, 16'h0200, 0, 3));
        drain("mul_wrap_drain");
        align();
        issue(2'b10, 4'b0110, 1, 1, 0, 0, 1, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 1,
              mk(16'h0000, 16'h0200, 1, 1));
        drain("mul_zero_drain");

        // Backpressure: hold 5 cycles, then same-cycle output+input handshake
        align();
        bus.out_ready = 1'b0;
        issue(2'b00, 4'b0000, 0, 1, 0, 0, 1, 16'h0010, 16'h0020, 16'h0001, 16'h0200, 1,
              mk(16'h0030, 16'h0202, 0, 1));
        @(negedge clk);
        check("stall_first_valid", bus.out_valid, 1);
        bus.alu_op = 2'b11; bus.func = 4'b0000; bus.alu_src = 1'b0; bus.reg_dst = 1'b1;
        bus.rs = 3'd0; bus.rt = 3'd0; bus.rd = 3'd6;
        bus.rs_data = 16'h0F00; bus.rt_data = 16'h00F0; bus.imm = 16'h00F0; bus.pc_next = 16'h0000;
        bus.in_valid = 1'b1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.alu_result !== 16'h0030 || bus.branch_target !== 16'h0202 ||
                bus.dest_reg !== 3'd1 || bus.zero !== 1'b0 || bus.in_ready !== 1'b0) bad++;
        end
        check("stall_hold_cycles", bad, 0);
        align();
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bb_in_ready", bus.in_ready, 1);
        @(posedge clk);
        sb_q.push_back(mk(16'h0FF0, 16'h01E0, 0, 6));
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("bb_out_valid", bus.out_valid, 1);
        check("bb_alu_result", bus.alu_result, 16'h0FF0);
        @(negedge clk);
        check("out_valid_cleared", bus.out_valid, 0);

        // Reset during MUL step 8 discards it
        align();
        issue(2'b10, 4'b0110, 0, 1, 0, 0, 5, 16'h0012, 16'h0034, 16'h0000, 16'h0000, 0,
              mk(16'h0000, 16'h0000, 0, 0));
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midmul_rst_out_valid", bus.out_valid, 0);
        check("midmul_rst_alu_result", bus.alu_result, 0);
        check("midmul_rst_branch_target", bus.branch_target, 0);
        check("midmul_rst_zero", bus.zero, 0);
        check("midmul_rst_dest_reg", bus.dest_reg, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midmul_rst_in_ready", bus.in_ready, 1);
        bad = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) bad++;
        end
        check("midmul_no_result", bad, 0);

        // Consumer of a held result in the next cycle
        align();
        issue(2'b00, 4'b0000, 0, 1, 0, 0, 2, 16'h0002, 16'h0003, 16'h0000, 16'h0000, 1,
              mk(16'h0005, 16'h0000, 0, 2));
`ifdef EXECUTE_PIPE_FWD_EN
        issue(2'b00, 4'b0000, 0, 1, 2, 4, 3, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 1,
              mk(16'h0006, 16'h0000, 0, 3));
`else
        issue(2'b00, 4'b0000, 0, 1, 2, 4, 3, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 1,
              mk(16'h0001, 16'h0000, 0, 3));
`endif
        drain("final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
